sap_control_sequencer: RTL and testbench

// - Microcode sequencer for the SAP CPU; drives PC, MAR, RAM, IR, A/B, ALU and output-register control strobes.
// - A step counter T0..T4 plus decode of the IR opcode produce one control word per clock.
// - In program mode (run=0) it parks and asserts nothing, so the dipswitch path owns RAM writes.

---
 rtl/sap_control_sequencer.sv | 164 ++++++++++++++++
 tb/tb_sap_control_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: microcode sequencer for the SAP CPU.
// A T-state counter (T0..T4) plus decode of the IR opcode produces one
// control word per clock. Fetch (T0/T1) is common; execute uses T2..T4 and
// each opcode returns to T0 right after its last active step.
//
// Ports:
//   clk        system clock, rising edge
//   clear_n    asynchronous active-low reset
//   run        1 = run, 0 = program mode (sequencer frozen, strobes 0)
//   ir_opcode  IR[7:4]
//   flag_c/z   ALU flags, used by JC/JZ only
//   pc_out .. pc_load  control strobes (combinational from step/opcode)
//   halted     sticky halt, cleared only by clear_n
//   step       current T-state
//
// Optional feature: define SAP_CTRL_JMP_EN to enable JMP/JC/JZ (0110/0111/1000).
// Without it those opcodes are NOPs, pc_load is tied 0 and the flags are unused.
module sap_control_sequencer #(
  parameter int MAX_STEPS = 5
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       run,
  input  logic [3:0] ir_opcode,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ram_write,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       flags_load,
  output logic       out_load,
  output logic       pc_load,
  output logic       halted,
  output logic [2:0] step
);

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, T7} tstate_e;

  localparam logic [3:0] OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
                         OP_STA = 4'h4, OP_LDI = 4'h5, OP_OUT = 4'hE,
                         OP_HLT = 4'hF;
`ifdef SAP_CTRL_JMP_EN
  localparam logic [3:0] OP_JMP = 4'h6, OP_JC = 4'h7, OP_JZ = 4'h8;
`endif
  localparam logic [2:0] LAST_STEP = 3'(MAX_STEPS - 1);

  tstate_e state_q, state_d;
  logic    halted_q, halted_d;
  logic    active;     // sequencer allowed to act this cycle
  logic    last;       // current step is the opcode's final one
  logic    halt_set;

  assign active = run & ~halted_q & clear_n;
  assign halted = halted_q;
  assign step   = state_q;

`ifndef SAP_CTRL_JMP_EN
  logic unused_flags;
  assign unused_flags = flag_c ^ flag_z;
  assign pc_load      = 1'b0;
`endif

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= T0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Control word decode; everything stays 0 unless the sequencer is active.
  always_comb begin
    pc_out = 1'b0; pc_inc = 1'b0; mar_load = 1'b0; ram_out = 1'b0;
    ram_write = 1'b0; ir_load = 1'b0; ir_out = 1'b0; a_load = 1'b0;
    a_out = 1'b0; b_load = 1'b0; alu_out = 1'b0; alu_sub = 1'b0;
    flags_load = 1'b0; out_load = 1'b0;
`ifdef SAP_CTRL_JMP_EN
    pc_load = 1'b0;
`endif
    last = 1'b0;
    halt_set = 1'b0;
    if (active) begin
      case (state_q)
        T0: begin
          pc_out = 1'b1; mar_load = 1'b1;
        end
        T1: begin
          ram_out = 1'b1; ir_load = 1'b1; pc_inc = 1'b1;
          // Anything without an execute phase ends after fetch.
          last = 1'b1;
          case (ir_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI, OP_OUT, OP_HLT: last = 1'b0;
`ifdef SAP_CTRL_JMP_EN
            OP_JMP, OP_JC, OP_JZ: last = 1'b0;
`endif
            default: ;
          endcase
        end
        T2: begin
          case (ir_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_out = 1'b1; mar_load = 1'b1;
            end
            OP_LDI: begin ir_out = 1'b1; a_load = 1'b1; last = 1'b1; end
            OP_OUT: begin a_out = 1'b1; out_load = 1'b1; last = 1'b1; end
            OP_HLT: begin halt_set = 1'b1; last = 1'b1; end
`ifdef SAP_CTRL_JMP_EN
            OP_JMP: begin ir_out = 1'b1; pc_load = 1'b1; last = 1'b1; end
            OP_JC: begin
              ir_out = flag_c; pc_load = flag_c; last = 1'b1;
            end
            OP_JZ: begin
              ir_out = flag_z; pc_load = flag_z; last = 1'b1;
            end
`endif
            default: last = 1'b1;
          endcase
        end
        T3: begin
          case (ir_opcode)
            OP_LDA: begin ram_out = 1'b1; a_load = 1'b1; last = 1'b1; end
            OP_ADD, OP_SUB: begin ram_out = 1'b1; b_load = 1'b1; end
            OP_STA: begin a_out = 1'b1; ram_write = 1'b1; last = 1'b1; end
            default: last = 1'b1;
          endcase
        end
        T4: begin
          last = 1'b1;
          if (ir_opcode == OP_ADD || ir_opcode == OP_SUB) begin
            alu_out = 1'b1; a_load = 1'b1; flags_load = 1'b1;
            alu_sub = (ir_opcode == OP_SUB);
          end
        end
        default: last = 1'b1;
      endcase
    end
  end

  // Step/halt advance: frozen in program mode or once halted.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (run && !halted_q) begin
      if (halt_set)
        halted_d = 1'b1;
      if (last || state_q == LAST_STEP)
        state_d = T0;
      else
        state_d = tstate_e'(state_q + 3'd1);
    end
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Scoreboard bench for sap_control_sequencer: a per-instruction micro-program
// table drives a reference model; expected outputs are queued per cycle and a
// negedge monitor compares them against the DUT.
module tb_sap_control_sequencer;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       run = 1'b0;
  logic [3:0] ir_opcode = 4'h0;
  logic       flag_c = 1'b0, flag_z = 1'b0;
  logic pc_out, pc_inc, mar_load, ram_out, ram_write, ir_load, ir_out;
  logic a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, pc_load;
  logic       halted;
  logic [2:0] step;

  sap_control_sequencer dut (
    .clk(clk), .clear_n(clear_n), .run(run), .ir_opcode(ir_opcode),
    .flag_c(flag_c), .flag_z(flag_z),
    .pc_out(pc_out), .pc_inc(pc_inc), .mar_load(mar_load), .ram_out(ram_out),
    .ram_write(ram_write), .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load),
    .a_out(a_out), .b_load(b_load), .alu_out(alu_out), .alu_sub(alu_sub),
    .flags_load(flags_load), .out_load(out_load), .pc_load(pc_load),
    .halted(halted), .step(step)
  );

  always #5 clk = ~clk;

  localparam logic [14:0] PC_OUT = 15'h4000, PC_INC = 15'h2000, MAR = 15'h1000,
    RAM_OUT = 15'h0800, RAM_WR = 15'h0400, IR_LOAD = 15'h0200, IR_OUT = 15'h0100,
    A_LOAD = 15'h0080, A_OUT = 15'h0040, B_LOAD = 15'h0020, ALU_OUT = 15'h0010,
    ALU_SUB = 15'h0008, FLAGS = 15'h0004, OUT_LOAD = 15'h0002, PC_LOAD = 15'h0001;

  logic [14:0] dut_w;
  assign dut_w = {pc_out, pc_inc, mar_load, ram_out, ram_write, ir_load, ir_out,
                  a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, pc_load};

  typedef struct {
    logic [2:0]  step;
    logic [14:0] w;
    logic        h;
    int          id;
  } exp_t;

  exp_t q[$];
  int checks = 0, fails = 0, cyc = 0;
  int mk = 0;      // model: index of the current step within the instruction
  bit mh = 0;      // model: halted

  // Control word of step k of an instruction.
  function automatic logic [14:0] uword(input logic [3:0] op, input int k,
                                        input logic fc, input logic fz);
    logic [14:0] e2, e3, e4;
    e2 = '0; e3 = '0; e4 = '0;
    case (op)
      4'h1: begin e2 = IR_OUT | MAR; e3 = RAM_OUT | A_LOAD; end
      4'h2: begin e2 = IR_OUT | MAR; e3 = RAM_OUT | B_LOAD; e4 = ALU_OUT | A_LOAD | FLAGS; end
      4'h3: begin e2 = IR_OUT | MAR; e3 = RAM_OUT | B_LOAD; e4 = ALU_OUT | A_LOAD | FLAGS | ALU_SUB; end
      4'h4: begin e2 = IR_OUT | MAR; e3 = A_OUT | RAM_WR; end
      4'h5: e2 = IR_OUT | A_LOAD;
      4'hE: e2 = A_OUT | OUT_LOAD;
`ifdef SAP_CTRL_JMP_EN
      4'h6: e2 = IR_OUT | PC_LOAD;
      4'h7: e2 = fc ? (IR_OUT | PC_LOAD) : 15'h0;
      4'h8: e2 = fz ? (IR_OUT | PC_LOAD) : 15'h0;
`endif
      default: ;
    endcase
    case (k)
      0: return PC_OUT | MAR;
      1: return RAM_OUT | IR_LOAD | PC_INC;
      2: return e2;
      3: return e3;
      4: return e4;
      default: return 15'h0;
    endcase
  endfunction

  // Total clock cycles an instruction occupies.
  function automatic int ilen(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      4'h5, 4'hE, 4'hF: return 3;
`ifdef SAP_CTRL_JMP_EN
      4'h6, 4'h7, 4'h8: return 3;
`endif
      default: return 2;
    endcase
  endfunction

  // One clock of stimulus: apply inputs, queue expectation, advance model.
  task automatic drive(input logic [3:0] op, input logic r, input logic fc, input logic fz);
    exp_t e;
    ir_opcode = op; run = r; flag_c = fc; flag_z = fz;
    e.step = 3'(mk);
    e.w    = (r && !mh) ? uword(op, mk, fc, fz) : 15'h0;
    e.h    = mh;
    e.id   = cyc;
    q.push_back(e);
    @(posedge clk); #1;
    cyc++;
    if (r && !mh) begin
      if (op == 4'hF && mk == 2) begin
        mh = 1; mk = 0;
      end else begin
        mk = mk + 1;
        if (mk >= ilen(op)) mk = 0;
      end
    end
  endtask

  // Async reset: the expectation is sampled before any further rising edge.
  task automatic do_reset();
    exp_t e;
    clear_n = 1'b0;
    mk = 0; mh = 0;
    e.step = 3'd0; e.w = 15'h0; e.h = 1'b0; e.id = cyc;
    q.push_back(e);
    @(posedge clk); #1;
    cyc++;
    clear_n = 1'b1;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic fc, input logic fz);
    drive(op, 1'b1, fc, fz);
    for (int i = 0; i < 8 && mk != 0; i++) drive(op, 1'b1, fc, fz);
  endtask

  // Monitor: one expectation per cycle, plus bus-driver exclusivity.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (step !== e.step || dut_w !== e.w || halted !== e.h) begin
        fails++;
        $display("FAIL cycle%0d: got step=%0d word=%h halted=%b, expected step=%0d word=%h halted=%b",
                 e.id, step, dut_w, halted, e.step, e.w, e.h);
      end
      checks++;
      if ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) > 1) begin
        fails++;
        $display("FAIL bus_excl cycle%0d: drivers=%b, expected at most one",
                 e.id, {pc_out, ram_out, ir_out, a_out, alu_out});
      end
    end
  end

  initial begin
    logic [3:0] op;
    logic fc, fz, r;
    @(posedge clk); #1;
    do_reset();                      // reset state (clear_n low from time 0)

    run_instr(4'h2, 1'b0, 1'b0);     // ADD, 5 cycles
    run_instr(4'h3, 1'b0, 1'b0);     // SUB

    // ADD interrupted by reset in T3
    drive(4'h2, 1'b1, 1'b0, 1'b0);
    drive(4'h2, 1'b1, 1'b0, 1'b0);
    drive(4'h2, 1'b1, 1'b0, 1'b0);
    do_reset();

    // STA with run dropped at T3
    for (int i = 0; i < 3; i++) drive(4'h4, 1'b1, 1'b0, 1'b0);
    drive(4'h4, 1'b0, 1'b0, 1'b0);
    drive(4'h4, 1'b0, 1'b0, 1'b0);
    drive(4'h4, 1'b1, 1'b0, 1'b0);

    // Jumps with both flag values
    run_instr(4'h7, 1'b0, 1'b0);
    run_instr(4'h7, 1'b1, 1'b0);
    run_instr(4'h8, 1'b0, 1'b0);
    run_instr(4'h8, 1'b0, 1'b1);
    run_instr(4'h6, 1'b0, 1'b0);

    // Sweep every non-halting opcode
    for (int o = 0; o < 15; o++) run_instr(4'(o), o[0], o[1]);

    // LDI; OUT; HLT then 20 idle clocks with random opcodes
    run_instr(4'h5, 1'b0, 1'b0);
    run_instr(4'hE, 1'b0, 1'b0);
    run_instr(4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0);
    do_reset();

    // Randomized run with frozen cycles and occasional halts
    op = 4'h0; fc = 1'b0; fz = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (mh && ($urandom_range(0, 5) == 0)) do_reset();
      if (mk == 0) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h5;
        fc = 1'($urandom); fz = 1'($urandom);
      end
      r = ($urandom_range(0, 6) != 0);
      drive(op, r, fc, fz);
    end

    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
